// File: rtl/decoder_8b10b.sv
// Receive-side 8b/10b decoder with running-disparity tracking and comma-based link lock.
// Latency: 1 clk from i_valid to o_valid; RD and lock state advance only on valid symbols.
// Backpressure: none; a new symbol may be accepted on every cycle that i_valid is high.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   i_en_data    10-bit symbol {a,b,c,d,e,i,f,g,h,j}, bit9 = a
//   i_valid      i_en_data is valid this cycle
//   o_data       decoded byte {H,G,F,E,D,C,B,A}; 8'h00 on code error
//   o_kout       symbol is one of the 12 legal K codes
//   o_valid      o_* outputs carry a freshly decoded symbol
//   o_code_err   symbol is not in the code table
//   o_disp_err   symbol is legal but has the wrong disparity for the current RD
//   o_rdisp      running disparity after this symbol (0 = RD-, 1 = RD+)
//   o_locked     lock FSM is in LOCKED
module decoder_8b10b #(
  parameter int ERR_LIMIT = 4,
  parameter int GOOD_RUN  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_en_data,
  input  logic       i_valid,
  output logic [7:0] o_data,
  output logic       o_kout,
  output logic       o_valid,
  output logic       o_code_err,
  output logic       o_disp_err,
  output logic       o_rdisp,
  output logic       o_locked
);

  localparam int ECW = $clog2(ERR_LIMIT + 1);
  localparam int GCW = $clog2(GOOD_RUN + 1);
  localparam logic [ECW-1:0] ERR_LAST  = ECW'(ERR_LIMIT - 1);
  localparam logic [GCW-1:0] GOOD_LAST = GCW'(GOOD_RUN - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t    r_state;
  logic           r_rd;
  logic [ECW-1:0] r_err_cnt;
  logic [GCW-1:0] r_good_cnt;

  logic [5:0] w_6b;
  logic [3:0] w_4b;
  logic       w_v6;
  logic [4:0] w_edcba;
  logic       w_v4;
  logic [2:0] w_hgf;
  logic       w_vk;
  logic [2:0] w_ky;
  logic       w_k28;
  logic       w_kx7;
  logic [3:0] w_ones6;
  logic [3:0] w_ones4;
  logic [3:0] w_ones10;
  logic       w_p6;
  logic       w_n6;
  logic       w_p4;
  logic       w_n4;
  logic       w_rd6;
  logic       w_rd4;
  logic       w_derr6;
  logic       w_derr4;
  logic       w_run5;
  logic       w_code_err;
  logic       w_disp_err;
  logic       w_err;
  logic       w_rd_next;
  logic [7:0] w_data;
  logic       w_kout;
  logic       w_comma;

  function automatic logic [3:0] popcnt(input logic [9:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < 10; k++) begin
      c = c + {3'b000, v[k]};
    end
    return c;
  endfunction

  function automatic logic run5(input logic [4:0] v);
    return (v == 5'b11111) || (v == 5'b00000);
  endfunction

  assign w_6b = i_en_data[9:4];
  assign w_4b = i_en_data[3:0];

  // 6b/5b table: both RD forms of every code; 000000/111111 fall to default.
  always_comb begin
    w_v6    = 1'b1;
    w_edcba = 5'd0;
    case (w_6b)
      6'b100111, 6'b011000: w_edcba = 5'd0;
      6'b011101, 6'b100010: w_edcba = 5'd1;
      6'b101101, 6'b010010: w_edcba = 5'd2;
      6'b110001:            w_edcba = 5'd3;
      6'b110101, 6'b001010: w_edcba = 5'd4;
      6'b101001:            w_edcba = 5'd5;
      6'b011001:            w_edcba = 5'd6;
      6'b111000, 6'b000111: w_edcba = 5'd7;
      6'b111001, 6'b000110: w_edcba = 5'd8;
      6'b100101:            w_edcba = 5'd9;
      6'b010101:            w_edcba = 5'd10;
      6'b110100:            w_edcba = 5'd11;
      6'b001101:            w_edcba = 5'd12;
      6'b101100:            w_edcba = 5'd13;
      6'b011100:            w_edcba = 5'd14;
      6'b010111, 6'b101000: w_edcba = 5'd15;
      6'b011011, 6'b100100: w_edcba = 5'd16;
      6'b100011:            w_edcba = 5'd17;
      6'b010011:            w_edcba = 5'd18;
      6'b110010:            w_edcba = 5'd19;
      6'b001011:            w_edcba = 5'd20;
      6'b101010:            w_edcba = 5'd21;
      6'b011010:            w_edcba = 5'd22;
      6'b111010, 6'b000101: w_edcba = 5'd23;
      6'b110011, 6'b001100: w_edcba = 5'd24;
      6'b100110:            w_edcba = 5'd25;
      6'b010110:            w_edcba = 5'd26;
      6'b110110, 6'b001001: w_edcba = 5'd27;
      6'b001110:            w_edcba = 5'd28;
      6'b101110, 6'b010001: w_edcba = 5'd29;
      6'b011110, 6'b100001: w_edcba = 5'd30;
      6'b101011, 6'b010100: w_edcba = 5'd31;
      6'b001111, 6'b110000: w_edcba = 5'd28;
      default:              w_v6    = 1'b0;
    endcase
  end

  // 4b/3b data table; D.x.7 accepts both primary and alternate forms.
  always_comb begin
    w_v4  = 1'b1;
    w_hgf = 3'd0;
    case (w_4b)
      4'b1011, 4'b0100:                   w_hgf = 3'd0;
      4'b1001:                            w_hgf = 3'd1;
      4'b0101:                            w_hgf = 3'd2;
      4'b1100, 4'b0011:                   w_hgf = 3'd3;
      4'b1101, 4'b0010:                   w_hgf = 3'd4;
      4'b1010:                            w_hgf = 3'd5;
      4'b0110:                            w_hgf = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: w_hgf = 3'd7;
      default:                            w_v4  = 1'b0;
    endcase
  end

  // K28 4b sub-blocks are tied to the polarity of the 6b: the neutral codes
  // (.1 .2 .5 .6) are inverted in the 110000 form, so they need their own table.
  always_comb begin
    w_vk = 1'b1;
    w_ky = 3'd0;
    if (!w_6b[5]) begin
      case (w_4b)
        4'b0100: w_ky = 3'd0;
        4'b1001: w_ky = 3'd1;
        4'b0101: w_ky = 3'd2;
        4'b0011: w_ky = 3'd3;
        4'b0010: w_ky = 3'd4;
        4'b1010: w_ky = 3'd5;
        4'b0110: w_ky = 3'd6;
        4'b1000: w_ky = 3'd7;
        default: w_vk = 1'b0;
      endcase
    end else begin
      case (w_4b)
        4'b1011: w_ky = 3'd0;
        4'b0110: w_ky = 3'd1;
        4'b1010: w_ky = 3'd2;
        4'b1100: w_ky = 3'd3;
        4'b1101: w_ky = 3'd4;
        4'b0101: w_ky = 3'd5;
        4'b1001: w_ky = 3'd6;
        4'b0111: w_ky = 3'd7;
        default: w_vk = 1'b0;
      endcase
    end
  end

  assign w_k28 = (w_6b == 6'b001111) || (w_6b == 6'b110000);

  // Kx.7 for x = 23, 27, 29, 30: those 6b codes paired with the alternate-style 4b.
  always_comb begin
    w_kx7 = 1'b0;
    case (w_6b)
      6'b111010, 6'b000101, 6'b110110, 6'b001001,
      6'b101110, 6'b010001, 6'b011110, 6'b100001:
        w_kx7 = (w_4b == 4'b1000) || (w_4b == 4'b0111);
      default: w_kx7 = 1'b0;
    endcase
  end

  assign w_ones6  = popcnt({4'b0000, w_6b});
  assign w_ones4  = popcnt({6'b000000, w_4b});
  assign w_ones10 = popcnt(i_en_data);

  assign w_p6 = (w_ones6 == 4'd4);
  assign w_n6 = (w_ones6 == 4'd2);
  assign w_p4 = (w_ones4 == 4'd3);
  assign w_n4 = (w_ones4 == 4'd1);

  // 6b checked against the incoming RD, 4b against the RD left by the 6b.
  assign w_derr6 = (w_p6 && r_rd) || (w_n6 && !r_rd) ||
                   ((w_6b == 6'b000111) && !r_rd) || ((w_6b == 6'b111000) && r_rd);
  assign w_rd6   = w_p6 ? 1'b1 : (w_n6 ? 1'b0 : r_rd);
  assign w_derr4 = (w_p4 && w_rd6) || (w_n4 && !w_rd6) ||
                   ((w_4b == 4'b0011) && !w_rd6) || ((w_4b == 4'b1100) && w_rd6);
  assign w_rd4   = w_p4 ? 1'b1 : (w_n4 ? 1'b0 : w_rd6);

  // Any run of five equal bits straddling the i/f boundary.
  assign w_run5 = run5(i_en_data[7:3]) || run5(i_en_data[6:2]) ||
                  run5(i_en_data[5:1]) || run5(i_en_data[4:0]);

  assign w_code_err = !w_v6 || (w_k28 ? !w_vk : !w_v4) || (w_run5 && !(w_k28 && w_vk));
  assign w_disp_err = !w_code_err && (w_derr6 || w_derr4);
  assign w_err      = w_code_err || w_disp_err;

  // An undecodable but unbalanced symbol still says something about line polarity.
  assign w_rd_next = w_code_err ? ((w_ones10 != 4'd5) ? !r_rd : r_rd) : w_rd4;

  assign w_data  = w_code_err ? 8'h00 : (w_k28 ? {w_ky, 5'd28} : {w_hgf, w_edcba});
  assign w_kout  = !w_code_err && (w_k28 || w_kx7);
  assign w_comma = !w_err && w_k28 &&
                   ((w_ky == 3'd1) || (w_ky == 3'd5) || (w_ky == 3'd7));

  assign o_rdisp = r_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data     <= 8'h00;
      o_kout     <= 1'b0;
      o_valid    <= 1'b0;
      o_code_err <= 1'b0;
      o_disp_err <= 1'b0;
      o_locked   <= 1'b0;
      r_rd       <= 1'b0;
      r_state    <= HUNT;
      r_err_cnt  <= '0;
      r_good_cnt <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data     <= w_data;
        o_kout     <= w_kout;
        o_code_err <= w_code_err;
        o_disp_err <= w_disp_err;
        r_rd       <= w_rd_next;
        case (r_state)
          HUNT: begin
            if (w_comma) begin
              r_state    <= LOCKED;
              o_locked   <= 1'b1;
              r_err_cnt  <= '0;
              r_good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_err) begin
              r_good_cnt <= '0;
              if (r_err_cnt != ECW'(ERR_LIMIT)) begin
                r_err_cnt <= r_err_cnt + ECW'(1);
              end
              // This error brings the count to ERR_LIMIT: drop lock on this edge.
              if (r_err_cnt >= ERR_LAST) begin
                r_state  <= HUNT;
                o_locked <= 1'b0;
              end
            end else if (r_good_cnt >= GOOD_LAST) begin
              r_good_cnt <= '0;
              r_err_cnt  <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + GCW'(1);
            end
          end
          default: begin
            r_state  <= HUNT;
            o_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
